// File: rtl/wr_arbiter_pkg.sv
// Shared definitions for the worker-result write arbiter: FSM encodings,
// default packet width and packet field helpers.
package wr_arbiter_pkg;

  localparam int PKT_WIDTH = 32;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_SEND = 1'b1
  } arb_state_e;

  // Packet layout: worker id in the top nibble, sequence/payload below.
  function automatic logic [PKT_WIDTH-1:0] pkt_make(input logic [3:0] worker,
                                                    input logic [PKT_WIDTH-5:0] seq);
    return {worker, seq};
  endfunction

  function automatic logic [3:0] pkt_worker(input logic [PKT_WIDTH-1:0] pkt);
    return pkt[PKT_WIDTH-1 -: 4];
  endfunction

endpackage

// File: rtl/wr_arbiter_if.sv
// Worker-result collection bus plus merged dispatcher output.
// Performance counter signals exist only when WR_ARBITER_PERF_EN is defined.
interface wr_arbiter_if
  import wr_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS         = 4,
  parameter int WORKER_RESULT_WIDTH = PKT_WIDTH
) ();

  localparam int GID_W = $clog2(NUM_WORKERS);

  logic [NUM_WORKERS-1:0]                     RECV_VALID;
  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECV_DATA;
  logic [NUM_WORKERS-1:0]                     RECV_READY;
  logic                                       SEND_VALID;
  logic [WORKER_RESULT_WIDTH-1:0]             SEND_DATA;
  logic                                       SEND_READY;
  logic [GID_W-1:0]                           GRANT_ID;
`ifdef WR_ARBITER_PERF_EN
  logic [31:0]                                PERF_XFER_COUNT;
  logic [31:0]                                PERF_STALL_COUNT;
`endif

  modport slave (
    input  RECV_VALID, RECV_DATA, SEND_READY,
`ifdef WR_ARBITER_PERF_EN
    output PERF_XFER_COUNT, PERF_STALL_COUNT,
`endif
    output RECV_READY, SEND_VALID, SEND_DATA, GRANT_ID
  );

  modport master (
    output RECV_VALID, RECV_DATA, SEND_READY,
`ifdef WR_ARBITER_PERF_EN
    input  PERF_XFER_COUNT, PERF_STALL_COUNT,
`endif
    input  RECV_READY, SEND_VALID, SEND_DATA, GRANT_ID
  );

endinterface

// File: rtl/wr_arbiter_rr_picker.sv
// Rotating priority picker: first asserted request at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_picker
  import wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    cand      = '0;
    hit       = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!hit && req_i[cand]) begin
        hit            = 1'b1;
        gnt_oh_o[cand] = 1'b1;
        gnt_idx_o      = cand;
      end
    end
    any_o = hit;
  end

endmodule

// File: rtl/wr_arbiter.sv
// Round-robin merge of per-worker results into one dispatcher stream.
// Define WR_ARBITER_PERF_EN to add saturating transfer/stall counters.
module wr_arbiter
  import wr_arbiter_pkg::*;
#(
  parameter int NUM_WORKERS         = 4,
  parameter int WORKER_RESULT_WIDTH = PKT_WIDTH
) (
  input  logic        CLK,
  input  logic        RST,
  wr_arbiter_if.slave bus
);

  // state  | meaning
  // S_ARB  | collecting: one-hot ready to the next round-robin requester
  // S_SEND | presenting the captured packet until the dispatcher accepts

  localparam int PTR_W = $clog2(NUM_WORKERS);

  arb_state_e                     state_q, state_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]               grant_id_q, grant_id_d;
  logic [WORKER_RESULT_WIDTH-1:0] send_data_q, send_data_d;

  logic [NUM_WORKERS-1:0]         pick_oh;
  logic [PTR_W-1:0]               pick_idx;
  logic                           pick_any;
  logic [NUM_WORKERS-1:0]         recv_ready;
  logic                           send_valid;
  logic [WORKER_RESULT_WIDTH-1:0] recv_slice [NUM_WORKERS];

  for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_slice
    assign recv_slice[i] = bus.RECV_DATA[i*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_WORKERS)
  ) u_picker (
    .req_i     (bus.RECV_VALID),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_ARB;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      send_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      send_data_q <= send_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    send_data_d = send_data_q;
    recv_ready  = '0;
    send_valid  = 1'b0;
    case (state_q)
      S_ARB: begin
        recv_ready = pick_oh;
        // Pointer only advances on a real transfer, so an idle cycle keeps priority.
        if (pick_any) begin
          send_data_d = recv_slice[pick_idx];
          grant_id_d  = pick_idx;
          rr_ptr_d    = (pick_idx == PTR_W'(NUM_WORKERS - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        send_valid = 1'b1;
        if (bus.SEND_READY) state_d = S_ARB;
      end
    endcase
  end

  // Outputs are gated by RST so nothing handshakes while reset is held.
  assign bus.RECV_READY = RST ? '0 : recv_ready;
  assign bus.SEND_VALID = send_valid & ~RST;
  assign bus.SEND_DATA  = RST ? '0 : send_data_q;
  assign bus.GRANT_ID   = RST ? '0 : grant_id_q;

`ifdef WR_ARBITER_PERF_EN
  logic [31:0] perf_xfer_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_xfer_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (send_valid && bus.SEND_READY && perf_xfer_q != '1)
        perf_xfer_q <= perf_xfer_q + 32'd1;
      if (send_valid && !bus.SEND_READY && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.PERF_XFER_COUNT  = perf_xfer_q;
  assign bus.PERF_STALL_COUNT = perf_stall_q;
`endif

endmodule

// File: tb/tb_wr_arbiter.sv
// Self-checking bench for wr_arbiter: vector table, hand-written corner
// sequences and a randomized per-worker scoreboard.
module tb_wr_arbiter;
  import wr_arbiter_pkg::*;

  localparam int NW = 4;
  localparam int W  = 32;
  localparam logic [31:0] D0 = 32'hD0D0_D0D0;
  localparam logic [31:0] D1 = 32'hD1D1_D1D1;
  localparam logic [31:0] D2 = 32'hD2D2_D2D2;
  localparam logic [31:0] D3 = 32'hD3D3_D3D3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  wr_arbiter_if #(.NUM_WORKERS(NW), .WORKER_RESULT_WIDTH(W)) bus ();

  wr_arbiter #(
    .NUM_WORKERS         (NW),
    .WORKER_RESULT_WIDTH (W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  valid;
    logic        sready;
    logic [3:0]  exp_ready;
    logic        exp_sv;
    logic [1:0]  exp_gid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] exp_q [NW][$];
  int          exp_g [$];
  logic [3:0]  pend;
  logic [31:0] cur_pkt [NW];
  int          seq [NW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST            = 1'b1;
    bus.RECV_VALID = '0;
    bus.SEND_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int last_cyc;
    int w;

    bus.RECV_VALID = '0;
    bus.RECV_DATA  = {D3, D2, D1, D0};
    bus.SEND_READY = 1'b0;

    // Reset holds readies and outputs low even with everything requesting.
    RST = 1'b1;
    bus.RECV_VALID = 4'b1111;
    bus.SEND_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", bus.RECV_READY, 4'b0000);
    chk("rst_send_valid", bus.SEND_VALID, 1'b0);
    chk("rst_send_data", bus.SEND_DATA, 32'h0);
    chk("rst_grant_id", bus.GRANT_ID, 2'd0);

    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 32'h0};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, D2};
    vecs[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd2, D2};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, D2};
    vecs[6]  = '{4'b1011, 1'b0, 4'b1000, 1'b0, 2'd2, D2};
    vecs[7]  = '{4'b1011, 1'b1, 4'b0000, 1'b1, 2'd3, D3};
    vecs[8]  = '{4'b1011, 1'b1, 4'b0001, 1'b0, 2'd3, D3};
    vecs[9]  = '{4'b1011, 1'b1, 4'b0000, 1'b1, 2'd0, D0};
    vecs[10] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, D0};
    vecs[11] = '{4'b1010, 1'b1, 4'b0000, 1'b1, 2'd1, D1};
    vecs[12] = '{4'b1010, 1'b1, 4'b1000, 1'b0, 2'd1, D1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, D3};
    vecs[14] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd3, D3};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, D0};
    vecs[16] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, D0};

    do_reset();
    for (int k = 0; k < 17; k++) begin
      bus.RECV_VALID = vecs[k].valid;
      bus.SEND_READY = vecs[k].sready;
      @(negedge CLK);
      chk($sformatf("vec%0d_ready", k), bus.RECV_READY, vecs[k].exp_ready);
      chk($sformatf("vec%0d_send_valid", k), bus.SEND_VALID, vecs[k].exp_sv);
      chk($sformatf("vec%0d_grant_id", k), bus.GRANT_ID, vecs[k].exp_gid);
      chk($sformatf("vec%0d_send_data", k), bus.SEND_DATA, vecs[k].exp_data);
      @(posedge CLK); #1;
    end

    // All workers valid, dispatcher always ready: 0,1,2,3,0 two cycles apart.
    do_reset();
    bus.RECV_VALID = 4'b1111;
    bus.SEND_READY = 1'b1;
    exp_g = '{0, 1, 2, 3, 0};
    got = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      @(negedge CLK);
      if (bus.SEND_VALID && bus.SEND_READY) begin
        chk($sformatf("rr_seq%0d_gid", got), bus.GRANT_ID, exp_g.pop_front());
        if (last_cyc >= 0) chk($sformatf("rr_seq%0d_gap", got), cyc - last_cyc, 2);
        last_cyc = cyc;
        got++;
      end
      @(posedge CLK); #1;
    end
    chk("rr_seq_count", got, 5);

    // Dispatcher stalls five cycles while every worker keeps requesting.
    do_reset();
    bus.RECV_VALID = 4'b0010;
    bus.SEND_READY = 1'b0;
    @(negedge CLK);
    chk("stall_grant_ready", bus.RECV_READY, 4'b0010);
    @(posedge CLK); #1;
    bus.RECV_VALID = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d_send_valid", k), bus.SEND_VALID, 1'b1);
      chk($sformatf("stall%0d_grant_id", k), bus.GRANT_ID, 2'd1);
      chk($sformatf("stall%0d_send_data", k), bus.SEND_DATA, D1);
      chk($sformatf("stall%0d_ready", k), bus.RECV_READY, 4'b0000);
      @(posedge CLK); #1;
    end
    bus.SEND_READY = 1'b1;
    @(negedge CLK);
    chk("stall_release_valid", bus.SEND_VALID, 1'b1);
`ifdef WR_ARBITER_PERF_EN
    chk("perf_stall_count", bus.PERF_STALL_COUNT, 32'd5);
    chk("perf_xfer_before", bus.PERF_XFER_COUNT, 32'd0);
`endif
    @(posedge CLK); #1;
    bus.SEND_READY = 1'b0;
    @(negedge CLK);
    chk("stall_after_valid", bus.SEND_VALID, 1'b0);
    chk("stall_after_ready", bus.RECV_READY, 4'b0100);
`ifdef WR_ARBITER_PERF_EN
    chk("perf_xfer_after", bus.PERF_XFER_COUNT, 32'd1);
    chk("perf_stall_hold", bus.PERF_STALL_COUNT, 32'd5);
`endif
    @(posedge CLK); #1;

    // Reset while presenting a packet with the pointer already advanced.
    do_reset();
    bus.RECV_VALID = 4'b1111;
    bus.SEND_READY = 1'b0;
    @(negedge CLK);
    chk("rstsend_g0_ready", bus.RECV_READY, 4'b0001);
    @(posedge CLK); #1;
    bus.SEND_READY = 1'b1;
    @(negedge CLK);
    chk("rstsend_g0_gid", bus.GRANT_ID, 2'd0);
    @(posedge CLK); #1;
    bus.SEND_READY = 1'b0;
    @(negedge CLK);
    chk("rstsend_g1_ready", bus.RECV_READY, 4'b0010);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstsend_pre_valid", bus.SEND_VALID, 1'b1);
    chk("rstsend_pre_gid", bus.GRANT_ID, 2'd1);
    RST = 1'b1;
    #1;
    chk("rstsend_during_valid", bus.SEND_VALID, 1'b0);
    chk("rstsend_during_ready", bus.RECV_READY, 4'b0000);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rstsend_post_valid", bus.SEND_VALID, 1'b0);
    chk("rstsend_post_ready", bus.RECV_READY, 4'b0001);
    chk("rstsend_post_gid", bus.GRANT_ID, 2'd0);
    chk("rstsend_post_data", bus.SEND_DATA, 32'h0);
    @(posedge CLK); #1;

    // Randomized traffic against per-worker in-order scoreboards.
    do_reset();
    pend = '0;
    for (int i = 0; i < NW; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NW; i++) begin
        if (!pend[i] && cyc < 340 && $urandom_range(0, 2) == 0) begin
          cur_pkt[i] = pkt_make(4'(i), 28'(seq[i]));
          seq[i]++;
          pend[i] = 1'b1;
          exp_q[i].push_back(cur_pkt[i]);
        end
        bus.RECV_DATA[i*W +: W] = pend[i] ? cur_pkt[i] : $urandom;
      end
      bus.RECV_VALID = pend;
      bus.SEND_READY = (cyc >= 340) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("rand_ready_onehot", $countones(bus.RECV_READY) <= 1, 1'b1);
      for (int i = 0; i < NW; i++)
        if (pend[i] && bus.RECV_READY[i]) pend[i] = 1'b0;
      if (bus.SEND_VALID && bus.SEND_READY) begin
        w = int'(bus.GRANT_ID);
        chk("rand_pkt_owner", pkt_worker(bus.SEND_DATA), bus.GRANT_ID);
        chk("rand_sb_pending", exp_q[w].size() != 0, 1'b1);
        if (exp_q[w].size() != 0)
          chk($sformatf("rand_w%0d_data", w), bus.SEND_DATA, exp_q[w].pop_front());
      end
      @(posedge CLK); #1;
    end
    chk("rand_all_accepted", pend, 4'b0000);
    for (int i = 0; i < NW; i++)
      chk($sformatf("rand_w%0d_drained", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
